// File: rtl/pipelined_adder_pkg.sv
// padd_pkg: shared operation-mode type and chunk-width helper for the pipelined adder.
package padd_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// adder_slice: combinational W-bit add of one carry chunk; also exposes the carry into its MSB
// so the final chunk can derive signed overflow.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s        = w_full[W-1:0];
    assign cout     = w_full[W];
    // a^b^s recovers the carry that entered the top bit of this chunk
    assign c_msb_in = a[W-1] ^ b[W-1] ^ w_full[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-chunked adder/subtractor with valid/ready flow control.
// Define PIPELINED_ADDER_SAT_EN to saturate the sum to signed min/max on overflow.
module pipelined_adder
    import padd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (WIDTH < 2) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be at least 2");
    end
    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    op_e              w_op;
    logic [WIDTH-1:0] w_b_in;

    logic             r_v     [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_s     [STAGES];
    logic             r_c     [STAGES];
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_rdy   [STAGES];
    logic             w_v_src [STAGES];
    logic [WIDTH-1:0] w_a_src [STAGES];
    logic [WIDTH-1:0] w_b_src [STAGES];
    logic [WIDTH-1:0] w_s_src [STAGES];
    logic             w_c_src [STAGES];
    logic [CW-1:0]    w_chunk [STAGES];
    logic [WIDTH-1:0] w_s_new [STAGES];
    logic             w_co    [STAGES];
    logic             w_cm    [STAGES];

    assign w_op   = sub ? OP_SUB : OP_ADD;
    assign w_b_in = (w_op == OP_SUB) ? ~b : b;

    // A stage may load when empty or when everything downstream of it moves this cycle.
    always_comb begin
        w_rdy[STAGES-1] = ~r_v[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_rdy[k] = ~r_v[k] | w_rdy[k+1];
        end
    end

    assign in_ready = w_rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_v_src[k] = in_valid;
            assign w_a_src[k] = a;
            assign w_b_src[k] = w_b_in;
            assign w_s_src[k] = '0;
            assign w_c_src[k] = cin;
        end else begin : g_body
            assign w_v_src[k] = r_v[k-1];
            assign w_a_src[k] = r_a[k-1];
            assign w_b_src[k] = r_b[k-1];
            assign w_s_src[k] = r_s[k-1];
            assign w_c_src[k] = r_c[k-1];
        end

        adder_slice #(
            .W(CW)
        ) u_slice (
            .a        (w_a_src[k][k*CW +: CW]),
            .b        (w_b_src[k][k*CW +: CW]),
            .cin      (w_c_src[k]),
            .s        (w_chunk[k]),
            .cout     (w_co[k]),
            .c_msb_in (w_cm[k])
        );

        // Upper sum chunks are still zero, so OR-ing in the new chunk is enough.
        assign w_s_new[k] = w_s_src[k] | (WIDTH'(w_chunk[k]) << (k * CW));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[k] <= 1'b0;
            end else if (w_rdy[k]) begin
                r_v[k] <= w_v_src[k];
            end
        end

        if (k == STAGES - 1) begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (w_rdy[k] && w_v_src[k]) begin
                    r_sum  <= w_s_new[k];
                    r_cout <= w_co[k];
                    r_ovf  <= w_co[k] ^ w_cm[k];
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (w_rdy[k] && w_v_src[k]) begin
                    r_a[k] <= w_a_src[k];
                    r_b[k] <= w_b_src[k];
                    r_s[k] <= w_s_new[k];
                    r_c[k] <= w_co[k];
                end
            end
        end
    end

`ifdef PIPELINED_ADDER_SAT_EN
    // A wrapped result with MSB set means the true value overflowed upward, and vice versa.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s, input logic v);
        if (!v) begin
            return s;
        end
        return s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    assign sum = saturate(r_sum, r_ovf);
`else
    assign sum = r_sum;
`endif

    assign out_valid = r_v[STAGES-1];
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: table-driven and sequence tests for pipelined_adder (WIDTH=16, STAGES=4).
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic        op;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   out_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;
    bit   rand_ready = 1'b0;

    function automatic logic [15:0] exp_sat(input logic [15:0] wrap, input logic ov, input logic a_msb);
`ifdef PIPELINED_ADDER_SAT_EN
        if (ov) return a_msb ? 16'h8000 : 16'h7FFF;
`endif
        return wrap;
    endfunction

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic op);
        logic [15:0] yy;
        logic [16:0] f;
        exp_t        e;
        yy   = op ? ~y : y;
        f    = {1'b0, x} + {1'b0, yy} + 17'(ci);
        e.co = f[16];
        e.ov = (x[15] == yy[15]) && (f[15] != x[15]);
        e.s  = exp_sat(f[15:0], e.ov, x[15]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Output monitor: scoreboard pop on transfer, stability check while stalled.
    logic        hold_pend = 1'b0;
    logic [17:0] held      = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) check("hold_stable", {13'd0, out_valid, sum, cout, ovf}, {13'd0, 1'b1, held});
                hold_pend = 1'b0;
                if (out_valid && !out_ready) begin
                    hold_pend = 1'b1;
                    held      = {sum, cout, ovf};
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got sum %h with empty scoreboard", sum);
                    end else begin
                        e = sb.pop_front();
                        check("result", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.co, e.ov});
                        out_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic try_send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic op,
                            input exp_t e, output bit ok);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = op;
        in_valid = 1'b1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        ok = in_ready;
        if (ok) begin
            sb.push_back(e);
            acc_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic op, input exp_t e);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) try_send(x, y, ci, op, e, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, want 1", in_ready);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t vt[12];
        exp_t e;
        bit   ok;
        int   acc;
        int   idx;
        int   gaps;
        logic [15:0] rx, ry;
        logic rci, rop;

        vt[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[5]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        vt[8]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[9]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};
        vt[11] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single op latency
        out_ready = 1'b1;
        out_cyc.delete();
        e.s = exp_sat(vt[0].s, vt[0].ov, vt[0].x[15]); e.co = vt[0].co; e.ov = vt[0].ov;
        send(vt[0].x, vt[0].y, vt[0].ci, vt[0].op, e);
        wait_drain("latency");
        if (out_cyc.size() > 0) check("latency", 32'(out_cyc[0] - acc_cyc), 32'd4);
        else check("latency_count", 32'(out_cyc.size()), 32'd1);

        // Table vectors back to back
        out_cyc.delete();
        for (int i = 0; i < 12; i++) begin
            e.s  = exp_sat(vt[i].s, vt[i].ov, vt[i].x[15]);
            e.co = vt[i].co;
            e.ov = vt[i].ov;
            send(vt[i].x, vt[i].y, vt[i].ci, vt[i].op, e);
        end
        wait_drain("table");
        check("b2b_count", 32'(out_cyc.size()), 32'd12);
        gaps = 0;
        for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] != out_cyc[i-1] + 1) gaps++;
        check("b2b_gaps", 32'(gaps), 32'd0);

        // Random operands with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            rci = 1'($urandom_range(0, 1));
            rop = 1'($urandom_range(0, 1));
            send(rx, ry, rci, rop, model(rx, ry, rci, rop));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain("random");

        // Full stall: only STAGES operations fit
        out_ready = 1'b0;
        acc = 0;
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            rx = 16'(idx * 16'h0111);
            ry = 16'h0100 + 16'(idx);
            try_send(rx, ry, 1'b0, 1'b0, model(rx, ry, 1'b0, 1'b0), ok);
            if (ok) begin
                acc++;
                idx++;
            end
        end
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_cyc.delete();
        out_ready = 1'b1;
        wait_drain("bp");
        check("bp_released", 32'(out_cyc.size()), 32'd4);

        // Reset with three operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h0100 * 16'(i + 1), 16'h0011, 1'b0, 1'b0, model(16'h0100 * 16'(i + 1), 16'h0011, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_out", {14'd0, sum, cout, ovf}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        out_cyc.delete();
        e.s = exp_sat(vt[7].s, vt[7].ov, vt[7].x[15]); e.co = vt[7].co; e.ov = vt[7].ov;
        send(vt[7].x, vt[7].y, vt[7].ci, vt[7].op, e);
        wait_drain("post_rst");
        repeat (6) @(negedge clk);
        check("post_rst_count", 32'(out_cyc.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
